i2s_tdm_tx: RTL and testbench

Parametrised I2S/TDM audio serializer; next generation of the fixed stereo I2S output path on the toi2s top. Accepts PCM samples over a valid/ready stream, double-buffers one full frame, and generates `i2s_bck`, `i2s_ws` and `i2s_d0` with configurable sample width, slot width, channel count and framing mode. A missing frame is reported as an underrun, and that frame is sent as zeros. Sits between the S/PDIF decoder / sample source and the amplifier pins.

---
 rtl/i2s_tdm_tx.sv | 173 +++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
// rtl/i2s_tdm_tx.sv - parametrised I2S/TDM audio serializer with double-buffered frame load
// Ports:
//   clk, resetb (sync, active low), ena (run enable), mode (0 = I2S, 1 = TDM DSP-A)
//   s_data/s_valid/s_ready : PCM sample stream, channel order ch0..chN-1
//   i2s_bck/i2s_ws/i2s_d0  : serial audio outputs, ws/d0 change on falling bck
//   underrun               : one-clk pulse, frame started without a complete load buffer
//   frame_start            : one-clk pulse at each frame boundary
module i2s_tdm_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int BCK_DIV  = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              ena,
  input  logic              mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              i2s_bck,
  output logic              i2s_ws,
  output logic              i2s_d0,
  output logic              underrun,
  output logic              frame_start
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int POS_W = $clog2(SLOT_W);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int WC_W  = $clog2(CHANNELS + 1);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_q;
  logic [POS_W-1:0]  bit_q, bit_d;
  logic [CH_W-1:0]   slot_q, slot_d;
  logic [WC_W-1:0]   wc_q;
  logic [DATA_W-1:0] load_buf  [CHANNELS];
  logic [DATA_W-1:0] shift_buf [CHANNELS];
  logic              bck_q, ws_q, d0_q, dly_q, mode_q, fs_q, un_q;
  logic              div_tc, fall_evt, boundary, swap, short_frame, accept;
  logic              ws_d, content_d;
  logic [DATA_W-1:0] next_word;
  logic [IDX_W-1:0]  bit_idx;

  assign s_ready     = (wc_q < WC_W'(CHANNELS));
  assign accept      = s_valid && s_ready;
  assign div_tc      = (div_q == DIV_W'(BCK_DIV - 1));
  assign i2s_bck     = bck_q;
  assign i2s_ws      = ws_q;
  assign i2s_d0      = d0_q;
  assign underrun    = un_q;
  assign frame_start = fs_q;

  // The first enabled clk counts as a falling bck edge at frame position 0,
  // so a frame boundary happens immediately on enable.
  always_comb begin
    state_d  = state_q;
    fall_evt = 1'b0;
    bit_d    = bit_q;
    slot_d   = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          state_d  = ST_RUN;
          fall_evt = 1'b1;
          bit_d    = '0;
          slot_d   = '0;
        end
      end
      ST_RUN: begin
        if (!ena) begin
          state_d = ST_IDLE;
        end else if (div_tc && bck_q) begin
          fall_evt = 1'b1;
          if (bit_q == POS_W'(SLOT_W - 1)) begin
            bit_d  = '0;
            slot_d = (slot_q == CH_W'(CHANNELS - 1)) ? '0 : slot_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign boundary    = fall_evt && (bit_d == '0) && (slot_d == '0);
  assign swap        = boundary && (wc_q == WC_W'(CHANNELS));
  assign short_frame = boundary && !swap;

  // Word feeding the new position, taken from the shift buffer as it will
  // look after this clk (fresh copy on swap, zeros on underrun).
  always_comb begin
    next_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (slot_d == CH_W'(i)) next_word = swap ? load_buf[i] : shift_buf[i];
    end
    if (short_frame) next_word = '0;
  end

  assign bit_idx   = IDX_W'(DATA_W - 1 - int'(bit_d));
  assign content_d = (int'(bit_d) < DATA_W) ? next_word[bit_idx] : 1'b0;
  // Mode is latched at frame start; at the boundary itself the live input applies.
  assign ws_d      = (boundary ? mode : mode_q) ? boundary
                                                : (int'(slot_d) >= CHANNELS / 2);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      wc_q    <= '0;
      bck_q   <= 1'b0;
      ws_q    <= 1'b0;
      d0_q    <= 1'b0;
      dly_q   <= 1'b0;
      mode_q  <= 1'b0;
      fs_q    <= 1'b0;
      un_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        load_buf[i]  <= '0;
        shift_buf[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fs_q    <= boundary;
      un_q    <= short_frame;

      if (swap) wc_q <= '0;
      else if (accept) wc_q <= wc_q + 1'b1;

      for (int i = 0; i < CHANNELS; i++) begin
        if (accept && (wc_q == WC_W'(i))) load_buf[i] <= s_data;
        if (swap) shift_buf[i] <= load_buf[i];
        else if (short_frame) shift_buf[i] <= '0;
      end

      if (!ena) begin
        div_q  <= '0;
        bit_q  <= '0;
        slot_q <= '0;
        bck_q  <= 1'b0;
        ws_q   <= 1'b0;
        d0_q   <= 1'b0;
        dly_q  <= 1'b0;
      end else begin
        if (state_q == ST_RUN) begin
          if (div_tc) begin
            div_q <= '0;
            bck_q <= ~bck_q;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        // d0 lags slot content by one bck: emit the held bit, hold the new one.
        if (fall_evt) begin
          bit_q  <= bit_d;
          slot_q <= slot_d;
          ws_q   <= ws_d;
          d0_q   <= dly_q;
          dly_q  <= content_d;
          if (boundary) mode_q <= mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb/tb_i2s_tdm_tx.sv - randomized self-checking bench for i2s_tdm_tx against a frame-level model
module tb_i2s_tdm_tx;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, ena, mode, s_valid;
  logic [23:0] s_data;
  logic        a_ready, a_bck, a_ws, a_d0, a_un, a_fs;
  logic        b_ready, b_bck, b_ws, b_d0, b_un, b_fs;
  logic        o_ready, o_bck, o_ws, o_d0, o_un, o_fs;
  logic        sel;

  always #5 clk = ~clk;

  i2s_tdm_tx #(.DATA_W(24), .SLOT_W(32), .CHANNELS(2), .BCK_DIV(2)) dut_a (
    .clk(clk), .resetb(rst_a), .ena(ena), .mode(mode), .s_data(s_data),
    .s_valid(s_valid), .s_ready(a_ready), .i2s_bck(a_bck), .i2s_ws(a_ws),
    .i2s_d0(a_d0), .underrun(a_un), .frame_start(a_fs));

  i2s_tdm_tx #(.DATA_W(24), .SLOT_W(24), .CHANNELS(8), .BCK_DIV(2)) dut_b (
    .clk(clk), .resetb(rst_b), .ena(ena), .mode(mode), .s_data(s_data),
    .s_valid(s_valid), .s_ready(b_ready), .i2s_bck(b_bck), .i2s_ws(b_ws),
    .i2s_d0(b_d0), .underrun(b_un), .frame_start(b_fs));

  assign o_ready = sel ? b_ready : a_ready;
  assign o_bck   = sel ? b_bck   : a_bck;
  assign o_ws    = sel ? b_ws    : a_ws;
  assign o_d0    = sel ? b_d0    : a_d0;
  assign o_un    = sel ? b_un    : a_un;
  assign o_fs    = sel ? b_fs    : a_fs;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: time is counted in clks since enable (k); the bit
  // index, slot and frame are plain divisions of k.
  int          p_ch, p_slot, p_data, p_div;
  bit          running, f_mode;
  int          k, m_wc;
  logic [23:0] load_m [8];
  logic [23:0] cur_f  [8];
  logic [23:0] prev_f [8];
  logic        e_bck, e_ws, e_d0, e_fs, e_un;
  bit          last_acc;

  task automatic set_params(input int ch, input int slot, input int data, input int div);
    p_ch = ch; p_slot = slot; p_data = data; p_div = div;
  endtask

  function automatic logic content_bit(input int m, input int n);
    int fb, qq, c, p;
    logic [23:0] w;
    fb = p_ch * p_slot;
    qq = m % fb;
    c  = qq / p_slot;
    p  = qq % p_slot;
    w  = (m / fb == n / fb) ? cur_f[c] : prev_f[c];
    if (p < p_data) return w[p_data-1-p];
    return 1'b0;
  endfunction

  task automatic model_step();
    bit rb, acc;
    int n, q, fb, fclk;
    rb   = sel ? rst_b : rst_a;
    fb   = p_ch * p_slot;
    fclk = 2 * p_div * fb;
    e_fs = 1'b0;
    e_un = 1'b0;
    if (!rb) begin
      m_wc = 0; running = 1'b0; k = 0;
      foreach (load_m[i]) load_m[i] = '0;
      e_bck = 1'b0; e_ws = 1'b0; e_d0 = 1'b0;
      return;
    end
    acc = s_valid && (m_wc < p_ch);
    if (ena) begin
      if (!running) begin running = 1'b1; k = 0; end
      else k++;
      if (k % fclk == 0) begin
        e_fs   = 1'b1;
        prev_f = cur_f;
        f_mode = mode;
        if (m_wc == p_ch) begin
          cur_f = load_m;
          m_wc  = 0;
        end else begin
          foreach (cur_f[i]) cur_f[i] = '0;
          e_un = 1'b1;
        end
      end
      n     = k / (2 * p_div);
      q     = n % fb;
      e_bck = ((k / p_div) % 2) == 1;
      e_ws  = f_mode ? (q == 0) : ((q / p_slot) >= p_ch / 2);
      e_d0  = (n == 0) ? 1'b0 : content_bit(n - 1, n);
    end else begin
      running = 1'b0;
      e_bck = 1'b0; e_ws = 1'b0; e_d0 = 1'b0;
    end
    if (acc) begin
      load_m[m_wc] = s_data;
      m_wc++;
    end
  endtask

  task automatic cycle();
    logic pre_ready;
    pre_ready = o_ready;
    last_acc  = s_valid && pre_ready;
    @(posedge clk);
    model_step();
    #1;
    check("bck",         o_bck,   e_bck);
    check("ws",          o_ws,    e_ws);
    check("d0",          o_d0,    e_d0);
    check("frame_start", o_fs,    e_fs);
    check("underrun",    o_un,    e_un);
    check("s_ready",     o_ready, (m_wc < p_ch));
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_b = v;
    else rst_a = v;
  endtask

  task automatic random_run(input int cycles);
    for (int j = 0; j < cycles; j++) begin
      s_valid = ($urandom_range(0, 2) == 0);
      s_data  = 24'($urandom);
      if ($urandom_range(0, 599) == 0) ena = ~ena;
      if ($urandom_range(0, 299) == 0) mode = 1'($urandom);
      set_rst(($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1);
      cycle();
    end
    set_rst(1'b1);
  endtask

  logic [23:0] w0, w1;
  int          un_cnt, acc_cnt, ws_cnt;
  logic        lsb_seen;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; ena = 1'b1; mode = 1'b0;
    s_valid = 1'b0; s_data = '0; sel = 1'b0;
    set_params(2, 32, 24, 2);
    foreach (cur_f[i]) begin cur_f[i] = '0; prev_f[i] = '0; end
    f_mode = 1'b0;

    repeat (3) cycle();
    check("rst_ready", o_ready, 1'b1);
    check("rst_bck", o_bck, 1'b0);

    ena = 1'b0; rst_a = 1'b1;
    cycle();
    s_valid = 1'b1; s_data = 24'hA5A5A5; cycle();
    s_data = 24'h3C3C3C; cycle();
    s_valid = 1'b0; cycle();
    check("ready_full", o_ready, 1'b0);

    ena = 1'b1; mode = 1'b0; w0 = '0; w1 = '0;
    for (int j = 0; j < 256; j++) begin
      cycle();
      if (j == 0) begin
        check("first_fs", o_fs, 1'b1);
        check("first_un", o_un, 1'b0);
      end
      if (j % 4 == 0) begin
        if (j / 4 >= 1 && j / 4 <= 24) w0 = {w0[22:0], o_d0};
        if (j / 4 >= 33 && j / 4 <= 56) w1 = {w1[22:0], o_d0};
      end
    end
    check("slot0_word", w0, 24'hA5A5A5);
    check("slot1_word", w1, 24'h3C3C3C);

    un_cnt = 0;
    repeat (512) begin
      cycle();
      if (o_un) un_cnt++;
    end
    check("underrun_count", un_cnt, 2);

    s_valid = 1'b1; s_data = 24'h100000; acc_cnt = 0;
    for (int j = 0; j < 1024; j++) begin
      cycle();
      if (last_acc) begin
        acc_cnt++;
        s_data = s_data + 24'd1;
      end
      if (j == 255) check("bp_first_frame_accepts", acc_cnt, 2);
    end
    check("bp_total_accepts", acc_cnt, 8);

    s_valid = 1'b0;
    repeat (100) cycle();
    ena = 1'b0; cycle();
    check("ena_off_bck", o_bck, 1'b0);
    check("ena_off_ws", o_ws, 1'b0);
    check("ena_off_d0", o_d0, 1'b0);
    s_valid = 1'b1; s_data = 24'h5A0F33; cycle();
    s_data = 24'h81C3E7; cycle();
    s_valid = 1'b0;
    ena = 1'b1; cycle();
    check("ena_on_fs", o_fs, 1'b1);
    repeat (300) cycle();

    random_run(3000);
    ena = 1'b1;
    repeat (77) cycle();
    rst_a = 1'b0; cycle();
    check("mid_rst_bck", o_bck, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    rst_a = 1'b1;
    random_run(1500);

    ena = 1'b0; rst_a = 1'b0; s_valid = 1'b0;
    sel = 1'b1;
    set_params(8, 24, 24, 2);
    cycle();
    rst_b = 1'b1; mode = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1;
      s_data  = (c == 7) ? 24'h000001 : 24'($urandom);
      cycle();
    end
    s_valid = 1'b0;
    ena = 1'b1; ws_cnt = 0; lsb_seen = 1'b0;
    for (int j = 0; j < 1536; j++) begin
      cycle();
      if (o_ws) ws_cnt++;
      if (j == 768) begin
        check("tdm_second_fs", o_fs, 1'b1);
        lsb_seen = o_d0;
      end
    end
    check("tdm_ws_cycles", ws_cnt, 8);
    check("tdm_ch7_lsb", lsb_seen, 1'b1);
    random_run(2500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
